// File: rtl/tms1000_pkg.sv
// rtl/tms1000_pkg.sv - shared types and constants for the TMS1000 boot-time ROM loader
package tms1000_pkg;

    localparam int ROM_DEPTH       = 1024;
    localparam int ROM_ADDR_W      = $clog2(ROM_DEPTH);
    localparam logic [7:0] EEPROM_CMD_READ = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_WRITE,
        ST_CS_HOLD,
        ST_DONE
    } loader_state_e;

endpackage

// File: rtl/spi_byte_engine.sv
// rtl/spi_byte_engine.sv - SPI mode-0 byte shifter with SCLK half-period divider
module spi_byte_engine #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       active,
    output logic       sclk,
    output logic       mosi
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             active_q, active_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_q, bit_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             pend_q, pend_d;
    logic             done_q, done_d;

    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        div_d    = div_q;
        pend_d   = pend_q;
        done_d   = 1'b0;
        if (!active_q) begin
            if (go) begin
                active_d = 1'b1;
                shift_d  = tx_byte;
                mosi_d   = tx_byte[7];
                bit_d    = 3'd0;
                div_d    = '0;
                pend_d   = 1'b0;
            end
        end else begin
            // A go arriving mid-byte is queued so the next byte follows with no SCLK gap.
            if (go) begin
                pend_d = 1'b1;
            end
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (!sclk_q) begin
                    sclk_d  = 1'b1;
                    shift_d = {shift_q[6:0], miso};
                    done_d  = (bit_q == 3'd7);
                end else begin
                    sclk_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        if (pend_q || go) begin
                            shift_d = tx_byte;
                            mosi_d  = tx_byte[7];
                            bit_d   = 3'd0;
                            pend_d  = 1'b0;
                        end else begin
                            active_d = 1'b0;
                            mosi_d   = 1'b0;
                        end
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        mosi_d = shift_q[7];
                    end
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            shift_q  <= 8'h00;
            bit_q    <= 3'd0;
            div_q    <= '0;
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            pend_q   <= pend_d;
            done_q   <= done_d;
        end
    end

    assign rx_byte   = shift_q;
    assign byte_done = done_q;
    assign active    = active_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;

endmodule

// File: rtl/eeprom_rom_loader.sv
// rtl/eeprom_rom_loader.sv - copies a program image from SPI EEPROM into the TMS1000 program ROM
module eeprom_rom_loader #(
    parameter int          ROM_DEPTH = tms1000_pkg::ROM_DEPTH,
    parameter int          CLK_DIV   = 4,
    parameter logic [15:0] EE_BASE   = 16'h0000
) (
    input  logic                         raw_clk,
    input  logic                         button_reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         rom_we,
    output logic [$clog2(ROM_DEPTH)-1:0] rom_addr,
    output logic [7:0]                   rom_data,
    output logic                         eeprom_cs,
    output logic                         eeprom_clk,
    output logic                         eeprom_di,
    input  logic                         eeprom_do
);

    import tms1000_pkg::*;

    localparam int AW     = $clog2(ROM_DEPTH);
    localparam int CNT_W  = AW + 1;
    localparam int WAIT_W = $clog2(CLK_DIV) + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(ROM_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(ROM_DEPTH - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CLK_DIV - 1);

    loader_state_e     state_q, state_d;
    logic              cs_q, cs_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              go_q, go_d;
    logic [7:0]        tx_q, tx_d;
    logic              addr_lo_q, addr_lo_d;

    logic       spi_done;
    logic       spi_active;
    logic [7:0] spi_rx;

    spi_byte_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_spi (
        .clk       (raw_clk),
        .rst_n     (button_reset),
        .go        (go_q),
        .tx_byte   (tx_q),
        .miso      (eeprom_do),
        .rx_byte   (spi_rx),
        .byte_done (spi_done),
        .active    (spi_active),
        .sclk      (eeprom_clk),
        .mosi      (eeprom_di)
    );

    always_comb begin
        state_d   = state_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        done_d    = done_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        go_d      = 1'b0;
        tx_d      = tx_q;
        addr_lo_d = addr_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    wait_d    = '0;
                    cnt_d     = '0;
                    addr_lo_d = 1'b0;
                    state_d   = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                cs_d = 1'b0;
                if (wait_q == WAIT_LAST) begin
                    go_d    = 1'b1;
                    tx_d    = EEPROM_CMD_READ;
                    state_d = ST_CMD;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_CMD: begin
                if (spi_done) begin
                    go_d    = 1'b1;
                    tx_d    = EE_BASE[15:8];
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (spi_done) begin
                    go_d = 1'b1;
                    if (!addr_lo_q) begin
                        tx_d      = EE_BASE[7:0];
                        addr_lo_d = 1'b1;
                    end else begin
                        tx_d    = 8'h00;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // The next byte is requested here, not in WRITE, so the burst never stalls SCLK.
                if (spi_done) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[AW-1:0];
                    data_d  = spi_rx;
                    cnt_d   = cnt_q + CNT_W'(1);
                    go_d    = (cnt_q != CNT_LAST);
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wait_d  = '0;
                state_d = (cnt_q == CNT_FULL) ? ST_CS_HOLD : ST_DATA;
            end
            ST_CS_HOLD: begin
                if (!cs_q) begin
                    if (!spi_active) begin
                        cs_d = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge raw_clk or negedge button_reset) begin
        if (!button_reset) begin
            state_q   <= ST_IDLE;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= 8'h00;
            cnt_q     <= '0;
            wait_q    <= '0;
            go_q      <= 1'b0;
            tx_q      <= 8'h00;
            addr_lo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            go_q      <= go_d;
            tx_q      <= tx_d;
            addr_lo_q <= addr_lo_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rom_we    = we_q;
    assign rom_addr  = addr_q;
    assign rom_data  = data_q;
    assign eeprom_cs = cs_q;

endmodule

// File: tb/tb_eeprom_rom_loader.sv
// tb/tb_eeprom_rom_loader.sv - self-checking bench for eeprom_rom_loader with a behavioural SPI EEPROM
`timescale 1ns/1ps
module tb_eeprom_rom_loader;

    localparam int DEPTH = 128;
    localparam int AW    = $clog2(DEPTH);
    localparam int CDIV  = 4;

    typedef struct {
        logic        use_b;
        int          pattern;
        int          restart_at;
        int          exp_we;
        logic [15:0] exp_addr;
        logic [7:0]  exp_cmd;
        logic        exp_done;
    } vec_t;

    logic raw_clk = 1'b0;
    logic rst_n   = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic sel_b   = 1'b0;
    logic ee_do   = 1'b0;

    logic          busy_a, done_a, we_a, cs_a, clk_a, di_a;
    logic [AW-1:0] addr_a;
    logic [7:0]    data_a;
    logic          busy_b, done_b, we_b, cs_b, clk_b, di_b;
    logic [AW-1:0] addr_b;
    logic [7:0]    data_b;

    always #42 raw_clk = ~raw_clk;

    eeprom_rom_loader #(.ROM_DEPTH(DEPTH), .CLK_DIV(CDIV), .EE_BASE(16'h0000)) dut_a (
        .raw_clk(raw_clk), .button_reset(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .rom_we(we_a), .rom_addr(addr_a), .rom_data(data_a), .eeprom_cs(cs_a),
        .eeprom_clk(clk_a), .eeprom_di(di_a), .eeprom_do(ee_do));

    eeprom_rom_loader #(.ROM_DEPTH(DEPTH), .CLK_DIV(CDIV), .EE_BASE(16'h0400)) dut_b (
        .raw_clk(raw_clk), .button_reset(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .rom_we(we_b), .rom_addr(addr_b), .rom_data(data_b), .eeprom_cs(cs_b),
        .eeprom_clk(clk_b), .eeprom_di(di_b), .eeprom_do(ee_do));

    logic          cs_m, sclk_m, di_m, we_m, busy_m, done_m;
    logic [AW-1:0] addr_m;
    logic [7:0]    data_m;
    assign cs_m   = sel_b ? cs_b   : cs_a;
    assign sclk_m = sel_b ? clk_b  : clk_a;
    assign di_m   = sel_b ? di_b   : di_a;
    assign we_m   = sel_b ? we_b   : we_a;
    assign busy_m = sel_b ? busy_b : busy_a;
    assign done_m = sel_b ? done_b : done_a;
    assign addr_m = sel_b ? addr_b : addr_a;
    assign data_m = sel_b ? data_b : data_a;

    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural EEPROM: READ command, 16-bit address, then auto-incrementing data.
    logic [7:0]  mem [65536];
    logic [7:0]  ee_cmd;
    logic [15:0] ee_addr;
    int          ee_bits;
    int          cs_falls;
    int          di_data_bad;

    always @(negedge cs_m) begin
        ee_bits = 0;
        ee_cmd  = 8'h00;
        ee_addr = 16'h0000;
        cs_falls++;
    end

    always @(posedge sclk_m) begin
        if (!cs_m) begin
            if (ee_bits < 8) ee_cmd = {ee_cmd[6:0], di_m};
            else if (ee_bits < 24) ee_addr = {ee_addr[14:0], di_m};
            else if (di_m) di_data_bad++;
            ee_bits++;
        end
    end

    always @(negedge sclk_m) begin
        int k;
        logic [7:0] b;
        if (!cs_m && ee_bits >= 24) begin
            k = ee_bits - 24;
            b = mem[16'(ee_addr + 16'(k / 8))];
            ee_do = b[7 - (k % 8)];
        end
    end

    // Bus monitor and ROM-write scoreboard.
    logic [15:0] exp_base = 16'h0000;
    int  cyc = 0;
    int  we_count, last_rise, last_we, rises, cs_fall_cyc, cs_rise_cyc, done_cyc, first_gap;
    int  period_bad, mosi_bad, sclk_cs_bad, we_gap_bad, we_timing_bad, we_width_bad;
    logic sclk_p = 1'b0, mosi_p = 1'b0, we_p = 1'b0, cs_p = 1'b1, done_p = 1'b0;

    always @(negedge raw_clk) begin
        cyc++;
        if (cs_p && !cs_m) begin
            cs_fall_cyc = cyc;
            rises = 0;
        end
        if (!cs_p && cs_m) cs_rise_cyc = cyc;
        if (done_m && !done_p) done_cyc = cyc;
        if (sclk_m && cs_m) sclk_cs_bad++;
        if (sclk_m && sclk_p && (di_m !== mosi_p)) mosi_bad++;
        if (sclk_m && !sclk_p) begin
            if (rises == 0) first_gap = cyc - cs_fall_cyc;
            else if (cyc - last_rise != 2 * CDIV) period_bad++;
            rises++;
            last_rise = cyc;
        end
        if (we_m) begin
            if (we_p) we_width_bad++;
            if (cyc - last_rise != 1 || rises != 24 + 8 * (we_count + 1)) we_timing_bad++;
            if (we_count > 0 && cyc - last_we != 16 * CDIV) we_gap_bad++;
            check(int'(addr_m) == we_count, "rom_addr", int'(addr_m), we_count);
            check(data_m == mem[16'(exp_base + 16'(we_count))], "rom_data", int'(data_m),
                  int'(mem[16'(exp_base + 16'(we_count))]));
            we_count++;
            last_we = cyc;
        end
        sclk_p = sclk_m;
        mosi_p = di_m;
        we_p   = we_m;
        cs_p   = cs_m;
        done_p = done_m;
    end

    task automatic prep(input vec_t v);
        sel_b    = v.use_b;
        exp_base = v.use_b ? 16'h0400 : 16'h0000;
        for (int j = 0; j < 65536; j++)
            mem[j] = (v.pattern == 0) ? (8'(j) ^ 8'h5A) : 8'($urandom);
        @(negedge raw_clk);
        we_count = 0; cs_falls = 0; di_data_bad = 0; period_bad = 0; mosi_bad = 0;
        sclk_cs_bad = 0; we_gap_bad = 0; we_timing_bad = 0; we_width_bad = 0;
        first_gap = 0; done_cyc = 0; cs_rise_cyc = 0;
    endtask

    task automatic do_start(input logic b);
        repeat ($urandom_range(1, 20)) @(negedge raw_clk);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge raw_clk);
        start_a = 1'b0;
        start_b = 1'b0;
        check(busy_m == 1'b1, "busy_rise", int'(busy_m), 1);
        check(done_m == 1'b0, "done_clear", int'(done_m), 0);
        check(cs_m == 1'b1, "cs_before_fall", int'(cs_m), 1);
        @(negedge raw_clk);
        check(cs_m == 1'b0, "cs_fall", int'(cs_m), 0);
    endtask

    task automatic wait_writes(input int target);
        int n = 0;
        while (we_count < target && n < 15000) begin
            @(negedge raw_clk);
            n++;
        end
        check(we_count >= target, "wait_writes_timeout", we_count, target);
    endtask

    task automatic finish_load(input vec_t v);
        int n = 0;
        while (!done_m && n < 15000) begin
            @(negedge raw_clk);
            n++;
        end
        check(done_m == v.exp_done, "done", int'(done_m), int'(v.exp_done));
        @(negedge raw_clk);
        check(busy_m == 1'b0, "busy_end", int'(busy_m), 0);
        check(cs_m == 1'b1, "cs_end", int'(cs_m), 1);
        check(we_count == v.exp_we, "we_count", we_count, v.exp_we);
        check(ee_cmd == v.exp_cmd, "mosi_cmd", int'(ee_cmd), int'(v.exp_cmd));
        check(ee_addr == v.exp_addr, "mosi_addr", int'(ee_addr), int'(v.exp_addr));
        check(cs_falls == 1, "cs_falls", cs_falls, 1);
        check(period_bad == 0, "sclk_period", period_bad, 0);
        check(mosi_bad == 0, "mosi_stable_high", mosi_bad, 0);
        check(sclk_cs_bad == 0, "sclk_idle_cs_high", sclk_cs_bad, 0);
        check(di_data_bad == 0, "mosi_zero_data", di_data_bad, 0);
        check(we_gap_bad == 0, "we_spacing", we_gap_bad, 0);
        check(we_timing_bad == 0, "we_after_rise", we_timing_bad, 0);
        check(we_width_bad == 0, "we_width", we_width_bad, 0);
        check(first_gap >= CDIV, "cs_to_first_rise", first_gap, CDIV);
        check(done_cyc - cs_rise_cyc >= CDIV, "cs_rise_to_done", done_cyc - cs_rise_cyc, CDIV);
    endtask

    task automatic run_load(input vec_t v);
        prep(v);
        do_start(v.use_b);
        if (v.restart_at >= 0) begin
            wait_writes(v.restart_at);
            if (v.use_b) start_b = 1'b1; else start_a = 1'b1;
            @(negedge raw_clk);
            start_a = 1'b0;
            start_b = 1'b0;
            check(busy_m == 1'b1, "busy_after_restart", int'(busy_m), 1);
        end
        finish_load(v);
    endtask

    vec_t vecs [4];
    vec_t v_rst;

    initial begin
        vecs[0] = '{use_b: 1'b0, pattern: 0, restart_at: -1, exp_we: DEPTH,
                    exp_addr: 16'h0000, exp_cmd: 8'h03, exp_done: 1'b1};
        vecs[1] = '{use_b: 1'b0, pattern: 0, restart_at: 100, exp_we: DEPTH,
                    exp_addr: 16'h0000, exp_cmd: 8'h03, exp_done: 1'b1};
        vecs[2] = '{use_b: 1'b1, pattern: 0, restart_at: -1, exp_we: DEPTH,
                    exp_addr: 16'h0400, exp_cmd: 8'h03, exp_done: 1'b1};
        vecs[3] = '{use_b: 1'b1, pattern: 1, restart_at: -1, exp_we: DEPTH,
                    exp_addr: 16'h0400, exp_cmd: 8'h03, exp_done: 1'b1};
        v_rst   = vecs[0];

        repeat (3) @(negedge raw_clk);
        check(cs_a == 1'b1, "rst_cs", int'(cs_a), 1);
        check(clk_a == 1'b0, "rst_sclk", int'(clk_a), 0);
        check(di_a == 1'b0, "rst_di", int'(di_a), 0);
        check(we_a == 1'b0, "rst_we", int'(we_a), 0);
        check(addr_a == '0, "rst_addr", int'(addr_a), 0);
        check(data_a == 8'h00, "rst_data", int'(data_a), 0);
        check(busy_a == 1'b0, "rst_busy", int'(busy_a), 0);
        check(done_a == 1'b0, "rst_done", int'(done_a), 0);
        check(cs_b == 1'b1, "rst_cs_b", int'(cs_b), 1);
        #10 rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_load(vecs[i]);

        // Reset in the middle of the data burst, then a clean reload from byte 0.
        prep(v_rst);
        do_start(1'b0);
        wait_writes(50);
        repeat ($urandom_range(1, 40)) @(negedge raw_clk);
        #10 rst_n = 1'b0;
        #1;
        check(cs_a == 1'b1, "midrst_cs", int'(cs_a), 1);
        check(clk_a == 1'b0, "midrst_sclk", int'(clk_a), 0);
        check(busy_a == 1'b0, "midrst_busy", int'(busy_a), 0);
        check(done_a == 1'b0, "midrst_done", int'(done_a), 0);
        check(we_count < DEPTH, "midrst_partial", we_count, DEPTH - 1);
        @(negedge raw_clk);
        #10 rst_n = 1'b1;
        run_load(v_rst);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eeprom_rom_loader.md
# eeprom_rom_loader

Boot-time loader that sits directly upstream of the TMS1000 core's 1024×8 program ROM. When the core selects the EEPROM program source (program-select button held at reset), this block reads the program image from an external SPI EEPROM and writes it byte-by-byte into the ROM. It then signals `done` so the core can leave its start-up delay state and begin fetching at page 0xF, pc 0. It replaces the core's unimplemented EEPROM start path.

## Interface
Parameters:
- `ROM_DEPTH`, 1024: number of bytes copied; also sets `rom_addr` width (log2).
- `CLK_DIV`, 4: `raw_clk` cycles per SCLK half-period; minimum 2.
- `EE_BASE`, 16'h0000: first EEPROM byte address read.

Ports:
- `raw_clk`, in, 1: 12 MHz system clock; the only clock.
- `button_reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request to begin a load.
- `busy`, out, 1: high from the cycle after an accepted `start` until `done` rises.
- `done`, out, 1: sticky high after the last ROM write; cleared by reset or an accepted `start`.
- `rom_we`, out, 1: ROM write strobe; one `raw_clk` cycle per byte.
- `rom_addr`, out, 10: ROM write address, equal to the byte index 0..ROM_DEPTH-1.
- `rom_data`, out, 8: ROM write data; valid while `rom_we` is high.
- `eeprom_cs`, out, 1: SPI chip select, active-low.
- `eeprom_clk`, out, 1: SPI SCLK, mode 0.
- `eeprom_di`, out, 1: SPI MOSI (EEPROM data-in).
- `eeprom_do`, in, 1: SPI MISO (EEPROM data-out).

## Operation
- Reset values: `eeprom_cs`=1, `eeprom_clk`=0, `eeprom_di`=0, `rom_we`=0, `rom_addr`=0, `rom_data`=0, `busy`=0, `done`=0, state=IDLE.
- A reset assertion in any state takes effect immediately. CS deasserts asynchronously, and a partial load leaves `done`=0.
- States and transitions:
  - IDLE: on `start`, clear `done`, set `busy`, and go to CS_SETUP. A `start` seen while `busy` is ignored.
  - CS_SETUP: drive `eeprom_cs`=0 and hold one SCLK half-period, then go to CMD.
  - CMD: shift out 8'h03 (READ) MSB first, then go to ADDR.
  - ADDR: shift out `EE_BASE`, 16 bits, MSB first, then go to DATA.
  - DATA: shift in 8 bits MSB first, then go to WRITE.
  - WRITE: pulse `rom_we` for one cycle and increment the byte counter.
    - If count == ROM_DEPTH, go to CS_HOLD.
    - Otherwise return to DATA. CS stays low; this is one sequential-read burst.
  - CS_HOLD: drive `eeprom_cs`=1 and wait one SCLK half-period, then go to DONE.
  - DONE: set `done`=1 and `busy`=0, then return to IDLE.
- SPI mode 0:
  - `eeprom_di` changes only while SCLK is low.
  - `eeprom_do` is sampled in the `raw_clk` cycle in which SCLK rises.
  - SCLK idles low and is held low while CS is high.
- During DATA, `eeprom_di`=0.
- Byte counter width is log2(ROM_DEPTH)+1 so it never wraps before the terminal compare.
- The EEPROM address is sent once only; the block relies on the EEPROM's internal auto-increment.

## Timing
- SCLK period is 2×`CLK_DIV` `raw_clk` cycles; 1.5 MHz at the defaults.
- Total SCLK cycles per load = 8 + 16 + 8×ROM_DEPTH = 8216 at the defaults.
- `rom_we` rises exactly 1 `raw_clk` cycle after the SCLK rising edge that samples bit 0 of each byte.
- `rom_addr` and `rom_data` are stable from that cycle until the next byte's `rom_we`.
- Consecutive `rom_we` pulses are 8 SCLK periods apart.
- `busy` rises 1 cycle after `start`. `eeprom_cs` falls 1 cycle after `busy` rises.
- `done` rises at least one SCLK half-period after `eeprom_cs` returns high.
- The first SCLK rising edge occurs no earlier than one half-period after CS falls.

## Structure
- Shared package `tms1000_pkg`:
  - loader state enum
  - `EEPROM_CMD_READ` = 8'h03
  - `ROM_DEPTH`
  - `ROM_ADDR_W`
- Sub-module `spi_byte_engine`:
  - SCLK half-period divider plus an 8-bit bidirectional shift register.
  - Interface: `go`, `tx_byte`, `rx_byte`, `byte_done`.
  - The loader FSM sequences it: CMD, ADDR-hi, ADDR-lo, then DATA×N.

## Test plan
- Reset, then `start` with a behavioural EEPROM model preloaded with byte i = i[7:0] ^ 8'h5A. Required response:
  - MOSI shows 03 00 00.
  - 1024 `rom_we` pulses, with `rom_addr` 0..1023 and `rom_data` equal to the model bytes.
  - `done`=1 and `eeprom_cs`=1 at the end.
- Check SCLK period = 8 `raw_clk` cycles. Every MISO sample occurs on an SCLK rise, and MOSI never changes while SCLK is high.
- `start` pulsed again at byte 100 while `busy`: no restart, `rom_addr` continues 101, 102, …
- Reset asserted mid-DATA at byte 500: `eeprom_cs`=1 in the same cycle, `busy`=0, `done`=0. A new `start` reloads from address 0.
- `EE_BASE`=16'h0400: MOSI shows 03 04 00, and the first `rom_data` equals model byte 0x400.
- A second `start` after `done`: `done` clears 1 cycle later, and a full reload completes identically.
